lut_table_loader: RTL and testbench

LUT_TABLE_LOADER -- requirements
Module: lut_table_loader

---
 rtl/lut_table_loader_pkg.sv | 24 ++
 rtl/lut_table_ram.sv | 30 +++
 rtl/lut_table_loader.sv | 107 ++++++++++
 tb/tb_lut_table_loader.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lut_table_loader_pkg.sv
// Shared constants, state type and sizing helpers
// for the LUT neuron truth-table loader.
package lut_table_loader_pkg;

   localparam int IN_BITS_DEF = 8;
   localparam int LOAD_W_DEF  = 8;
   localparam int TABLE_DEPTH = 2 ** IN_BITS_DEF;
   localparam int WORDS       = TABLE_DEPTH / LOAD_W_DEF;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOAD   = 2'd1,
      S_ACTIVE = 2'd2
   } state_t;

   function automatic int words_of(int in_bits, int load_w);
      return (2 ** in_bits) / load_w;
   endfunction

   function automatic int cnt_w(int words);
      return (words > 1) ? $clog2(words) : 1;
   endfunction

endpackage

// File: rtl/lut_table_ram.sv
// Truth-table storage: word-wide write port,
// single-bit asynchronous read port. Not reset.
module lut_table_ram
   import lut_table_loader_pkg::*;
#(
   parameter int IN_BITS = IN_BITS_DEF,
   parameter int LOAD_W  = LOAD_W_DEF
) (
   input  logic                                      clk,
   input  logic                                      we,
   input  logic [cnt_w(words_of(IN_BITS,LOAD_W))-1:0] waddr,
   input  logic [LOAD_W-1:0]                         wdata,
   input  logic [IN_BITS-1:0]                        raddr,
   output logic                                      rdata
);

   localparam int DEPTH = 2 ** IN_BITS;

   (* rom_style = "distributed" *)
   logic [DEPTH-1:0] mem;

   always_ff @(posedge clk) begin
      if (we) begin
         mem[int'(waddr) * LOAD_W +: LOAD_W] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/lut_table_loader.sv
// Loads a LUT neuron truth table word by word,
// then serves single-bit lookups with a 1-cycle result.
module lut_table_loader
   import lut_table_loader_pkg::*;
#(
   parameter int IN_BITS = IN_BITS_DEF,
   parameter int LOAD_W  = LOAD_W_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load_start,
   input  logic [LOAD_W-1:0]  load_data,
   input  logic               load_valid,
   output logic               load_ready,
   output logic               load_done,
   output logic               table_valid,
   input  logic [IN_BITS-1:0] q_in,
   input  logic               q_valid,
   output logic               q_ready,
   output logic               q_out,
   output logic               q_out_valid,
   input  logic               q_out_ready
);

   localparam int NW = words_of(IN_BITS, LOAD_W);
   localparam int CW = cnt_w(NW);
   localparam logic [CW-1:0] LAST = CW'(NW - 1);

   state_t         state;
   state_t         state_nx;
   logic [CW-1:0]  wcnt;
   logic           wr_en;
   logic           last_wr;
   logic           q_fire;
   logic           rd_bit;

   assign load_ready  = (state == S_LOAD) && !load_start;
   assign wr_en       = load_valid && load_ready;
   assign last_wr     = wr_en && (wcnt == LAST);
   assign table_valid = (state == S_ACTIVE);
   assign q_ready     = (state == S_ACTIVE) && !load_start
                        && (!q_out_valid || q_out_ready);
   assign q_fire      = q_valid && q_ready;

   // load_start and last_wr cannot coincide: load_ready masks writes
   always_comb begin
      state_nx = state;
      unique case (1'b1)
         load_start: state_nx = S_LOAD;
         last_wr:    state_nx = S_ACTIVE;
         default:    state_nx = state;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wcnt      <= '0;
         load_done <= 1'b0;
      end else begin
         load_done <= last_wr;
         if (load_start) begin
            wcnt <= '0;
         end else if (wr_en) begin
            wcnt <= last_wr ? '0 : wcnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_out_valid <= 1'b0;
         q_out       <= 1'b0;
      end else begin
         if (load_start) begin
            q_out_valid <= 1'b0;
         end else if (q_fire) begin
            q_out_valid <= 1'b1;
         end else if (q_out_ready) begin
            q_out_valid <= 1'b0;
         end
         if (q_fire) begin
            q_out <= rd_bit;
         end
      end
   end

   lut_table_ram #(
      .IN_BITS (IN_BITS),
      .LOAD_W  (LOAD_W)
   ) u_ram (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wcnt),
      .wdata (load_data),
      .raddr (q_in),
      .rdata (rd_bit)
   );

endmodule

// File: tb/tb_lut_table_loader.sv
// Scoreboard bench for lut_table_loader: a bit-array
// table model feeds expected lookups to a monitor.
module tb_lut_table_loader;
   import lut_table_loader_pkg::*;

   localparam int IB = IN_BITS_DEF;
   localparam int LW = LOAD_W_DEF;
   localparam int NW = WORDS;
   localparam int DEPTH = TABLE_DEPTH;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          load_start = 1'b0;
   logic [LW-1:0] load_data = '0;
   logic          load_valid = 1'b0;
   logic          load_ready;
   logic          load_done;
   logic          table_valid;
   logic [IB-1:0] q_in = '0;
   logic          q_valid = 1'b0;
   logic          q_ready;
   logic          q_out;
   logic          q_out_valid;
   logic          q_out_ready = 1'b1;

   lut_table_loader #(.IN_BITS(IB), .LOAD_W(LW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_start  (load_start),
      .load_data   (load_data),
      .load_valid  (load_valid),
      .load_ready  (load_ready),
      .load_done   (load_done),
      .table_valid (table_valid),
      .q_in        (q_in),
      .q_valid     (q_valid),
      .q_ready     (q_ready),
      .q_out       (q_out),
      .q_out_valid (q_out_valid),
      .q_out_ready (q_out_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit val;
      int cyc;
   } exp_t;

   int   checks = 0;
   int   passes = 0;
   int   cyc = 0;
   bit   ref_tbl [DEPTH];
   int   wk = 0;
   bit   tv_m = 1'b0;
   int   loads_exp = 0;
   int   done_seen = 0;
   exp_t sb [$];

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                    name, act, exp, cyc);
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // monitor: every presented result is compared with the queue head
   initial begin : monitor
      bit   fresh;
      bit   prev_done;
      exp_t e;
      fresh = 1'b1;
      prev_done = 1'b0;
      forever begin
         @(negedge clk);
         if (load_done) begin
            done_seen++;
            chk("load_done_single_pulse", prev_done, 0);
         end
         prev_done = load_done;
         if (q_out_valid) begin
            if (sb.size() == 0) begin
               chk("spurious_q_out_valid", 1, 0);
            end else begin
               e = sb[0];
               if (fresh) begin
                  chk("q_latency", cyc, e.cyc + 1);
                  fresh = 1'b0;
               end
               chk("q_out", q_out, e.val);
               if (q_out_ready) begin
                  void'(sb.pop_front());
                  fresh = 1'b1;
               end
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(string tag);
      chk({tag, "_load_ready"}, load_ready, 0);
      chk({tag, "_load_done"}, load_done, 0);
      chk({tag, "_table_valid"}, table_valid, 0);
      chk({tag, "_q_ready"}, q_ready, 0);
      chk({tag, "_q_out_valid"}, q_out_valid, 0);
      chk({tag, "_q_out"}, q_out, 0);
   endtask

   task automatic start_load();
      load_start = 1'b1;
      @(negedge clk);
      chk("load_ready_in_start_cycle", load_ready, 0);
      chk("q_ready_in_start_cycle", q_ready, 0);
      tick();
      load_start = 1'b0;
      wk = 0;
      tv_m = 1'b0;
      @(negedge clk);
      chk("table_valid_after_start", table_valid, 0);
      chk("q_out_valid_after_start", q_out_valid, 0);
      chk("load_ready_in_load", load_ready, 1);
      tick();
   endtask

   task automatic send_word(logic [LW-1:0] d);
      int w;
      w = 0;
      load_valid = 1'b1;
      load_data = d;
      @(negedge clk);
      chk("table_valid_during_load", table_valid, tv_m);
      while (!load_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk("load_ready_word", load_ready, 1);
      tick();
      load_valid = 1'b0;
      for (int j = 0; j < LW; j++) ref_tbl[wk * LW + j] = d[j];
      if (wk == NW - 1) begin
         wk = 0;
         tv_m = 1'b1;
         loads_exp++;
         @(negedge clk);
         chk("load_done_after_last", load_done, 1);
         chk("table_valid_after_last", table_valid, 1);
         tick();
      end else begin
         wk++;
      end
   endtask

   task automatic load_words(int n, bit rnd, logic [LW-1:0] fill);
      for (int i = 0; i < n; i++) begin
         send_word(rnd ? LW'($urandom) : fill);
      end
   endtask

   task automatic query(logic [IB-1:0] a, bit rnd_rdy, output int waited);
      int   w;
      exp_t e;
      w = 0;
      q_valid = 1'b1;
      q_in = a;
      if (rnd_rdy) q_out_ready = 1'($urandom);
      @(negedge clk);
      while (!q_ready && w < 20) begin
         tick();
         if (rnd_rdy) q_out_ready = (w > 2) ? 1'b1 : 1'($urandom);
         @(negedge clk);
         w++;
      end
      chk("q_ready_accept", q_ready, 1);
      e.val = ref_tbl[a];
      e.cyc = cyc;
      sb.push_back(e);
      waited = w;
      tick();
   endtask

   task automatic drain();
      q_valid = 1'b0;
      q_out_ready = 1'b1;
      repeat (3) tick();
      chk("scoreboard_drained", sb.size(), 0);
   endtask

   task automatic query_blocked(logic [IB-1:0] a, int n);
      q_valid = 1'b1;
      q_in = a;
      repeat (n) begin
         @(negedge clk);
         chk("q_ready_blocked", q_ready, 0);
         chk("q_out_valid_blocked", q_out_valid, 0);
         tick();
      end
      q_valid = 1'b0;
   endtask

   initial begin
      int wt;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("reset");
      rst_n = 1'b1;

      // no table yet: queries refused
      query_blocked(8'h00, 4);
      chk("load_ready_idle", load_ready, 0);

      // A5 table, lookups 0x00,0x01,0x07 back to back
      start_load();
      load_words(NW, 1'b0, 8'hA5);
      query(8'h00, 1'b0, wt);
      query(8'h01, 1'b0, wt);
      chk("back_to_back_1", wt, 0);
      query(8'h07, 1'b0, wt);
      chk("back_to_back_2", wt, 0);
      drain();

      // result backpressure: q_out holds, next query waits
      q_out_ready = 1'b0;
      query(8'h07, 1'b0, wt);
      q_in = 8'h01;
      repeat (5) begin
         @(negedge clk);
         chk("stall_q_ready", q_ready, 0);
         chk("stall_q_out_valid", q_out_valid, 1);
         chk("stall_q_out", q_out, ref_tbl[7]);
         tick();
      end
      q_out_ready = 1'b1;
      @(negedge clk);
      chk("q_ready_on_release", q_ready, 1);
      begin
         exp_t e;
         e.val = ref_tbl[1];
         e.cyc = cyc;
         sb.push_back(e);
      end
      tick();
      drain();

      // restart after 10 words, then an all-ones table
      start_load();
      load_words(10, 1'b1, 8'h00);
      start_load();
      load_words(NW, 1'b0, 8'hFF);
      for (int i = 0; i < 16; i++) query(IB'($urandom), 1'b0, wt);
      drain();

      // reset in the middle of a load
      start_load();
      load_words(20, 1'b1, 8'h00);
      rst_n = 1'b0;
      #1;
      chk_all_zero("midload_reset");
      wk = 0;
      tv_m = 1'b0;
      tick();
      rst_n = 1'b1;
      load_valid = 1'b1;
      load_data = 8'h5A;
      repeat (4) begin
         @(negedge clk);
         chk("idle_load_ready", load_ready, 0);
         chk("idle_table_valid", table_valid, 0);
         tick();
      end
      load_valid = 1'b0;
      query_blocked(8'h10, 3);
      start_load();
      load_words(NW, 1'b1, 8'h00);
      for (int i = 0; i < 40; i++) query(IB'($urandom), 1'b1, wt);
      drain();

      // load_start with a query and a word in the same cycle
      load_start = 1'b1;
      q_valid = 1'b1;
      q_in = IB'($urandom);
      load_valid = 1'b1;
      load_data = 8'h3C;
      @(negedge clk);
      chk("collide_q_ready", q_ready, 0);
      chk("collide_load_ready", load_ready, 0);
      tick();
      load_start = 1'b0;
      q_valid = 1'b0;
      load_valid = 1'b0;
      wk = 0;
      tv_m = 1'b0;
      @(negedge clk);
      chk("collide_q_out_valid", q_out_valid, 0);
      chk("collide_table_valid", table_valid, 0);
      chk("collide_in_load", load_ready, 1);
      tick();
      load_words(NW, 1'b1, 8'h00);
      for (int i = 0; i < 16; i++) begin
         query(IB'($urandom), 1'b0, wt);
         chk("burst_no_wait", wt, 0);
      end
      for (int i = 0; i < 40; i++) query(IB'($urandom), 1'b1, wt);
      drain();

      chk("load_done_count", done_seen, loads_exp);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
